// File: rtl/counter_trigger_pkg.sv
// Shared types and sizing for the counter-delayed trigger sequencer.
package counter_trigger_pkg;

  localparam int unsigned COUNTER_WIDTH_DEF = 32;
  localparam int unsigned MAX_AVG_LOG2_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SKIP      = 3'd1,
    ST_ACQUIRE   = 3'd2,
    ST_ARM       = 3'd3,
    ST_WAIT_FIRE = 3'd4,
    ST_HOLD      = 3'd5,
    ST_DONE      = 3'd6
  } seq_state_t;

  // Accumulator must hold 2^max_log2 full-scale periods without overflow.
  function automatic int unsigned ACC_WIDTH(input int unsigned counter_width,
                                            input int unsigned max_log2);
    return counter_width + max_log2;
  endfunction

endpackage

// File: rtl/counter_period_averager.sv
// Accumulates 2^avg_log2 period samples and produces their truncated mean.
// Optional window restart on jitter is built when COUNTER_TRIGGER_JITTER_CHECK_EN is defined.
module counter_period_averager
  import counter_trigger_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int unsigned MAX_AVG_LOG2  = MAX_AVG_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     tick,
  input  logic [COUNTER_WIDTH-1:0] value,
  input  logic [COUNTER_WIDTH-1:0] jitter_tol,
  input  logic [3:0]               avg_log2,
  output logic [COUNTER_WIDTH-1:0] avg,
  output logic                     avg_valid,
  output logic                     jitter_reject
);

  localparam int unsigned ACC_W = ACC_WIDTH(COUNTER_WIDTH, MAX_AVG_LOG2);
  localparam int unsigned CNT_W = MAX_AVG_LOG2 + 1;

  logic [ACC_W-1:0]         r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [COUNTER_WIDTH-1:0] r_avg;
  logic                     r_avg_valid;
  logic                     r_jitter_reject;

  logic [ACC_W-1:0]         w_acc_sum;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic [CNT_W-1:0]         w_target;
  logic                     w_take;
  logic                     w_reject;

  assign w_acc_sum = r_acc + ACC_W'(value);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_target  = CNT_W'(1) << avg_log2;
  // Samples arriving after the window completes are dropped until the next clear.
  assign w_take    = tick && !r_avg_valid;

`ifdef COUNTER_TRIGGER_JITTER_CHECK_EN
  logic [COUNTER_WIDTH-1:0] r_sample0;
  logic [COUNTER_WIDTH-1:0] w_diff;

  assign w_diff   = (value >= r_sample0) ? (value - r_sample0) : (r_sample0 - value);
  assign w_reject = (r_cnt != '0) && (w_diff > jitter_tol);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample0 <= '0;
    end else if (clear) begin
      r_sample0 <= '0;
    end else if (w_take && ((r_cnt == '0) || w_reject)) begin
      r_sample0 <= value;
    end
  end
`else
  logic w_unused_tol;
  assign w_unused_tol = ^jitter_tol;
  assign w_reject     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc           <= '0;
      r_cnt           <= '0;
      r_avg           <= '0;
      r_avg_valid     <= 1'b0;
      r_jitter_reject <= 1'b0;
    end else if (clear) begin
      r_acc           <= '0;
      r_cnt           <= '0;
      r_avg           <= '0;
      r_avg_valid     <= 1'b0;
      r_jitter_reject <= 1'b0;
    end else begin
      r_jitter_reject <= w_take && w_reject;
      if (w_take) begin
        if (w_reject) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == w_target) begin
            r_avg_valid <= 1'b1;
            r_avg       <= COUNTER_WIDTH'(w_acc_sum >> avg_log2);
          end
        end
      end
    end
  end

  assign avg           = r_avg;
  assign avg_valid     = r_avg_valid;
  assign jitter_reject = r_jitter_reject;

endmodule

// File: rtl/counter_trigger_sequencer.sv
// Sequencer for the counter-delayed trigger: measure/average period, arm, hold after fire, reset.
// Jitter rejection inside the averager is built only when COUNTER_TRIGGER_JITTER_CHECK_EN is defined.
module counter_trigger_sequencer
  import counter_trigger_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int unsigned MAX_AVG_LOG2  = MAX_AVG_LOG2_DEF,
  parameter int unsigned HOLD_WIDTH    = 32,
  parameter int unsigned ERR_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic [3:0]               avg_log2,
  input  logic [HOLD_WIDTH-1:0]    hold_cycles,
  input  logic [COUNTER_WIDTH-1:0] jitter_tol,
  input  logic                     period_tick,
  input  logic [COUNTER_WIDTH-1:0] last_counter,
  input  logic                     trigger_armed,
  input  logic                     trigger,
  output logic                     trigger_arm,
  output logic                     trigger_reset,
  output logic [COUNTER_WIDTH-1:0] reference_counter,
  output logic                     reference_valid,
  output logic [2:0]               seq_state,
  output logic                     done,
  output logic [ERR_WIDTH-1:0]     jitter_error_count
);

  localparam int unsigned LOG_W = 4;

  seq_state_t               r_state, w_state_nxt;
  logic [HOLD_WIDTH-1:0]    r_hold_cnt, w_hold_nxt;
  logic [LOG_W-1:0]         r_avg_log2, w_avg_log2_nxt, w_avg_log2_clamped;
  logic [COUNTER_WIDTH-1:0] r_reference_counter, w_reference_nxt;
  logic                     r_reference_valid, w_reference_valid_nxt;
  logic                     r_trigger_arm, w_trigger_arm_nxt;
  logic                     r_trigger_reset, w_trigger_reset_nxt;
  logic                     r_done, w_done_nxt;
  logic [ERR_WIDTH-1:0]     r_jitter_error_count;
  logic                     w_abort_taken;

  logic                     w_avg_clear, w_avg_tick, w_avg_valid, w_jitter_reject;
  logic [COUNTER_WIDTH-1:0] w_avg;

  assign w_avg_log2_clamped = (avg_log2 > LOG_W'(MAX_AVG_LOG2)) ? LOG_W'(MAX_AVG_LOG2) : avg_log2;
  // The averager is held clear for the whole SKIP state, so the partial first period never counts.
  assign w_avg_clear = !enable || (r_state == ST_SKIP);
  assign w_avg_tick  = period_tick && (r_state == ST_ACQUIRE);

  counter_period_averager #(
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .MAX_AVG_LOG2  (MAX_AVG_LOG2)
  ) u_averager (
    .clk           (clk),
    .reset         (reset),
    .clear         (w_avg_clear),
    .tick          (w_avg_tick),
    .value         (last_counter),
    .jitter_tol    (jitter_tol),
    .avg_log2      (r_avg_log2),
    .avg           (w_avg),
    .avg_valid     (w_avg_valid),
    .jitter_reject (w_jitter_reject)
  );

  always_comb begin
    w_state_nxt           = r_state;
    w_hold_nxt            = r_hold_cnt;
    w_avg_log2_nxt        = r_avg_log2;
    w_reference_nxt       = r_reference_counter;
    w_reference_valid_nxt = r_reference_valid;
    w_abort_taken         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt           = ST_SKIP;
          w_reference_valid_nxt = 1'b0;
          w_avg_log2_nxt        = w_avg_log2_clamped;
        end
      end
      ST_SKIP: begin
        if (period_tick) w_state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (w_avg_valid) begin
          w_state_nxt           = ST_ARM;
          w_reference_nxt       = w_avg;
          w_reference_valid_nxt = 1'b1;
        end
      end
      ST_ARM: begin
        if (trigger_armed) w_state_nxt = ST_WAIT_FIRE;
      end
      ST_WAIT_FIRE: begin
        if (trigger) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = hold_cycles;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = ST_DONE;
        else                  w_hold_nxt  = r_hold_cnt - HOLD_WIDTH'(1);
      end
      ST_DONE: begin
        if (continuous) begin
          w_state_nxt    = ST_SKIP;
          w_avg_log2_nxt = w_avg_log2_clamped;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort overrides every other transition, including a completing average.
    if (abort && (r_state != ST_IDLE)) begin
      w_abort_taken         = 1'b1;
      w_state_nxt           = ST_IDLE;
      w_reference_nxt       = r_reference_counter;
      w_reference_valid_nxt = r_reference_valid;
    end

    // Outputs are registered from the next state so they line up with seq_state.
    w_trigger_arm_nxt   = (w_state_nxt == ST_ARM);
    w_trigger_reset_nxt = w_abort_taken || ((w_state_nxt == ST_HOLD) && (w_hold_nxt == '0));
    w_done_nxt          = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state              <= ST_IDLE;
      r_hold_cnt           <= '0;
      r_avg_log2           <= '0;
      r_reference_counter  <= '0;
      r_reference_valid    <= 1'b0;
      r_trigger_arm        <= 1'b0;
      r_trigger_reset      <= 1'b0;
      r_done               <= 1'b0;
      r_jitter_error_count <= '0;
    end else if (!enable) begin
      r_state              <= ST_IDLE;
      r_hold_cnt           <= '0;
      r_avg_log2           <= '0;
      r_reference_counter  <= '0;
      r_reference_valid    <= 1'b0;
      r_trigger_arm        <= 1'b0;
      r_trigger_reset      <= 1'b0;
      r_done               <= 1'b0;
      r_jitter_error_count <= '0;
    end else begin
      r_state             <= w_state_nxt;
      r_hold_cnt          <= w_hold_nxt;
      r_avg_log2          <= w_avg_log2_nxt;
      r_reference_counter <= w_reference_nxt;
      r_reference_valid   <= w_reference_valid_nxt;
      r_trigger_arm       <= w_trigger_arm_nxt;
      r_trigger_reset     <= w_trigger_reset_nxt;
      r_done              <= w_done_nxt;
      if (w_jitter_reject && (r_jitter_error_count != {ERR_WIDTH{1'b1}}))
        r_jitter_error_count <= r_jitter_error_count + ERR_WIDTH'(1);
    end
  end

  assign trigger_arm        = r_trigger_arm;
  assign trigger_reset      = r_trigger_reset;
  assign reference_counter  = r_reference_counter;
  assign reference_valid    = r_reference_valid;
  assign seq_state          = r_state;
  assign done               = r_done;
  assign jitter_error_count = r_jitter_error_count;

endmodule

// File: tb/tb_counter_trigger_sequencer.sv
// Directed bench for counter_trigger_sequencer; expectations depend on COUNTER_TRIGGER_JITTER_CHECK_EN.
module tb_counter_trigger_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, start, abort, continuous;
  logic [3:0]  avg_log2;
  logic [31:0] hold_cycles, jitter_tol, last_counter;
  logic        period_tick, trigger_armed, trigger;
  logic        trigger_arm, trigger_reset, reference_valid, done;
  logic [31:0] reference_counter;
  logic [2:0]  seq_state;
  logic [15:0] jitter_error_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef COUNTER_TRIGGER_JITTER_CHECK_EN
  localparam logic [31:0] JIT_REF = 32'd100;
  localparam logic [15:0] JIT_ERR = 16'd1;
`else
  localparam logic [31:0] JIT_REF = 32'd102;
  localparam logic [15:0] JIT_ERR = 16'd0;
`endif

  counter_trigger_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .start              (start),
    .abort              (abort),
    .continuous         (continuous),
    .avg_log2           (avg_log2),
    .hold_cycles        (hold_cycles),
    .jitter_tol         (jitter_tol),
    .period_tick        (period_tick),
    .last_counter       (last_counter),
    .trigger_armed      (trigger_armed),
    .trigger            (trigger),
    .trigger_arm        (trigger_arm),
    .trigger_reset      (trigger_reset),
    .reference_counter  (reference_counter),
    .reference_valid    (reference_valid),
    .seq_state          (seq_state),
    .done               (done),
    .jitter_error_count (jitter_error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick(input logic [31:0] v);
    last_counter = v;
    period_tick  = 1'b1;
    step();
    period_tick  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    avg_log2 = 4'd2; hold_cycles = 32'd3; jitter_tol = 32'd5; last_counter = '0;
    period_tick = 1'b0; trigger_armed = 1'b0; trigger = 1'b0;
    step(); step();
    check("rst_state", 32'(seq_state), 32'd0);
    check("rst_arm", 32'(trigger_arm), 32'd0);
    check("rst_ref", reference_counter, 32'd0);
    check("rst_valid", 32'(reference_valid), 32'd0);
    check("rst_err", 32'(jitter_error_count), 32'd0);
    reset = 1'b0; enable = 1'b1;
    step();

    // Single-shot run: average 4 periods, arm, fire, hold 3.
    start = 1'b1; step(); start = 1'b0;
    check("s1_skip", 32'(seq_state), 32'd1);
    tick(32'd1000);
    check("s1_acquire", 32'(seq_state), 32'd2);
    tick(32'd100); tick(32'd102); tick(32'd98); tick(32'd100);
    check("s1_last_tick_state", 32'(seq_state), 32'd2);
    check("s1_last_tick_valid", 32'(reference_valid), 32'd0);
    step();
    check("s1_arm_state", 32'(seq_state), 32'd3);
    check("s1_ref", reference_counter, 32'd100);
    check("s1_valid", 32'(reference_valid), 32'd1);
    check("s1_arm", 32'(trigger_arm), 32'd1);
    repeat (4) step();
    check("s1_arm_held", 32'(trigger_arm), 32'd1);
    trigger_armed = 1'b1; step();
    check("s1_wait_fire", 32'(seq_state), 32'd4);
    check("s1_arm_drop", 32'(trigger_arm), 32'd0);
    trigger = 1'b1; step();
    check("s1_hold", 32'(seq_state), 32'd5);
    check("s1_hold_rst0", 32'(trigger_reset), 32'd0);
    step(); step();
    check("s1_hold_rst2", 32'(trigger_reset), 32'd0);
    step();
    check("s1_trig_reset", 32'(trigger_reset), 32'd1);
    check("s1_trig_reset_state", 32'(seq_state), 32'd5);
    trigger = 1'b0; trigger_armed = 1'b0;
    step();
    check("s1_done_state", 32'(seq_state), 32'd6);
    check("s1_done", 32'(done), 32'd1);
    check("s1_reset_drop", 32'(trigger_reset), 32'd0);
    step();
    check("s1_idle", 32'(seq_state), 32'd0);
    check("s1_done_drop", 32'(done), 32'd0);
    check("s1_valid_kept", 32'(reference_valid), 32'd1);

    // Continuous run, hold 0, avg of 2; avg_log2 change mid-window has no effect.
    continuous = 1'b1; avg_log2 = 4'd1; hold_cycles = 32'd0;
    start = 1'b1; step(); start = 1'b0;
    check("s2_valid_cleared", 32'(reference_valid), 32'd0);
    tick(32'd500); tick(32'd200); tick(32'd202);
    step();
    check("s2_ref", reference_counter, 32'd201);
    trigger_armed = 1'b1; step();
    trigger = 1'b1; step();
    check("s2_hold0_reset", 32'(trigger_reset), 32'd1);
    check("s2_hold0_state", 32'(seq_state), 32'd5);
    trigger = 1'b0; trigger_armed = 1'b0;
    step();
    check("s2_done", 32'(done), 32'd1);
    step();
    check("s2_reskip", 32'(seq_state), 32'd1);
    check("s2_valid_kept", 32'(reference_valid), 32'd1);
    avg_log2 = 4'd3;
    tick(32'd999);
    check("s2_acquire2", 32'(seq_state), 32'd2);
    tick(32'd300); tick(32'd310);
    step();
    check("s2_arm2", 32'(seq_state), 32'd3);
    check("s2_ref2", reference_counter, 32'd305);

    // Abort in WAIT_FIRE with a coincident start.
    trigger_armed = 1'b1; step();
    check("ab_wait_fire", 32'(seq_state), 32'd4);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0; trigger_armed = 1'b0;
    check("ab_idle", 32'(seq_state), 32'd0);
    check("ab_reset_pulse", 32'(trigger_reset), 32'd1);
    check("ab_arm", 32'(trigger_arm), 32'd0);
    step();
    check("ab_reset_single", 32'(trigger_reset), 32'd0);
    check("ab_start_ignored", 32'(seq_state), 32'd0);
    continuous = 1'b0;

    // Jitter window restart.
    avg_log2 = 4'd2; jitter_tol = 32'd5;
    start = 1'b1; step(); start = 1'b0;
    tick(32'd1000);
    tick(32'd100); tick(32'd110); tick(32'd100); tick(32'd100); tick(32'd100); tick(32'd100);
    step();
    check("jit_state", 32'(seq_state), 32'd3);
    check("jit_ref", reference_counter, JIT_REF);
    check("jit_err", 32'(jitter_error_count), 32'(JIT_ERR));
    abort = 1'b1; step(); abort = 1'b0;

    // avg_log2 above the maximum clamps to 8 (256 samples).
    avg_log2 = 4'd9;
    start = 1'b1; step(); start = 1'b0;
    tick(32'd7);
    for (int i = 0; i < 255; i++) tick(32'd1234);
    step();
    check("clamp_not_yet", 32'(seq_state), 32'd2);
    tick(32'd1234);
    step();
    check("clamp_arm", 32'(seq_state), 32'd3);
    check("clamp_ref", reference_counter, 32'd1234);
    abort = 1'b1; step(); abort = 1'b0;

    // enable low mid-ACQUIRE clears everything.
    avg_log2 = 4'd2;
    start = 1'b1; step(); start = 1'b0;
    tick(32'd50); tick(32'd60);
    check("en_acquire", 32'(seq_state), 32'd2);
    enable = 1'b0; step();
    check("en_idle", 32'(seq_state), 32'd0);
    check("en_valid", 32'(reference_valid), 32'd0);
    check("en_ref", reference_counter, 32'd0);
    check("en_err", 32'(jitter_error_count), 32'd0);
    enable = 1'b1; step();

    // Async reset in HOLD.
    avg_log2 = 4'd0; hold_cycles = 32'd10;
    start = 1'b1; step(); start = 1'b0;
    tick(32'd9); tick(32'd77);
    step();
    check("rh_ref", reference_counter, 32'd77);
    trigger_armed = 1'b1; step();
    trigger = 1'b1; step(); step();
    check("rh_hold", 32'(seq_state), 32'd5);
    reset = 1'b1; #1;
    check("rh_state", 32'(seq_state), 32'd0);
    check("rh_ref0", reference_counter, 32'd0);
    check("rh_valid0", 32'(reference_valid), 32'd0);
    check("rh_arm0", 32'(trigger_arm), 32'd0);
    check("rh_reset0", 32'(trigger_reset), 32'd0);
    trigger = 1'b0; trigger_armed = 1'b0;
    step(); reset = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
